// File: rtl/reg_frame_stack.sv
`default_nettype none
// ============================================================================
// Module   : reg_frame_stack
// Purpose  : Saves and restores a fixed window of register-file entries as
//            LIFO frames, one register per clock, on backup/restore strobes.
// Revision : 1.0 - initial release
// ============================================================================
module reg_frame_stack #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 4,
   parameter int NREGS     = 4,
   parameter int FIRST_REG = 4,
   parameter int DEPTH     = 8,
   parameter int PTR_W     = 4
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              backup,
   input  logic              restore,
   input  logic              clr_err,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_we,
   output logic              busy,
   output logic [PTR_W-1:0]  depth,
   output logic              overflow,
   output logic              underflow,
   output logic              collide
);

   localparam int               c_IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int               c_SW       = (DEPTH * NREGS > 1) ? $clog2(DEPTH * NREGS) : 1;
   localparam int               c_SLOTS    = 1 << c_SW;
   localparam logic [c_IW-1:0]  c_LAST_IDX = c_IW'(NREGS - 1);
   localparam logic [PTR_W-1:0] c_FULL     = PTR_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SAVE = 2'd1,
      ST_LOAD = 2'd2
   } state_t;

   state_t             r_state;
   logic [c_IW-1:0]    r_idx;
   logic [PTR_W-1:0]   r_depth;
   logic               r_ovf;
   logic               r_unf;
   logic               r_col;
   logic [DATA_W-1:0]  r_stack [c_SLOTS];

   logic               w_idle;
   logic               w_last;
   logic               w_bk_req;
   logic               w_rs_req;
   logic               w_set_ovf;
   logic               w_set_unf;
   logic               w_set_col;
   logic [PTR_W-1:0]   w_frame;
   logic [c_SW-1:0]    w_slot;
   logic [ADDR_W-1:0]  w_addr;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_last    = (r_idx == c_LAST_IDX);
   assign w_bk_req  = w_idle & backup & ~restore;
   assign w_rs_req  = w_idle & restore & ~backup;
   assign w_set_ovf = w_bk_req & (r_depth == c_FULL);
   assign w_set_unf = w_rs_req & (r_depth == '0);
   // Any strobe while busy is a collision; in IDLE only the simultaneous pair is.
   assign w_set_col = w_idle ? (backup & restore) : (backup | restore);

   // A save fills the frame above the top; a load drains the top frame.
   assign w_frame = (r_state == ST_LOAD) ? (r_depth - PTR_W'(1)) : r_depth;
   assign w_slot  = c_SW'(32'(w_frame) * 32'(NREGS) + 32'(r_idx));
   assign w_addr  = ADDR_W'(32'(FIRST_REG) + 32'(r_idx));

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_depth <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_col   <= 1'b0;
      end else begin
         r_ovf <= w_set_ovf | (r_ovf & ~clr_err);
         r_unf <= w_set_unf | (r_unf & ~clr_err);
         r_col <= w_set_col | (r_col & ~clr_err);
         case (r_state)
            ST_IDLE: begin
               r_idx <= '0;
               if (w_bk_req && !w_set_ovf) begin
                  r_state <= ST_SAVE;
               end else if (w_rs_req && !w_set_unf) begin
                  r_state <= ST_LOAD;
               end
            end
            ST_SAVE, ST_LOAD: begin
               if (w_last) begin
                  r_idx   <= '0;
                  r_state <= ST_IDLE;
                  r_depth <= (r_state == ST_SAVE) ? (r_depth + PTR_W'(1))
                                                  : (r_depth - PTR_W'(1));
               end else begin
                  r_idx <= r_idx + c_IW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_idx   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == ST_SAVE) begin
         r_stack[w_slot] <= rf_rdata;
      end
   end

   assign busy      = ~w_idle;
   assign rf_we     = (r_state == ST_LOAD);
   assign rf_raddr  = (r_state == ST_SAVE) ? w_addr : '0;
   assign rf_waddr  = rf_we ? w_addr : '0;
   assign rf_wdata  = rf_we ? r_stack[w_slot] : '0;
   assign depth     = r_depth;
   assign overflow  = r_ovf;
   assign underflow = r_unf;
   assign collide   = r_col;

endmodule
`default_nettype wire

// File: tb/tb_reg_frame_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_frame_stack
// Purpose  : Self-checking bench for reg_frame_stack: directed scenarios plus
//            randomized strobes compared against a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_frame_stack;

   localparam int NREGS     = 4;
   localparam int FIRST_REG = 4;
   localparam int DEPTH     = 8;

   logic        clk;
   logic        Reset;
   logic        backup, restore, clr_err;
   logic [3:0]  rf_raddr, rf_waddr;
   logic [15:0] rf_rdata, rf_wdata;
   logic        rf_we, busy, overflow, underflow, collide;
   logic [3:0]  depth;

   reg_frame_stack #(
      .DATA_W(16), .ADDR_W(4), .NREGS(NREGS), .FIRST_REG(FIRST_REG),
      .DEPTH(DEPTH), .PTR_W(4)
   ) dut (
      .clk(clk), .Reset(Reset), .backup(backup), .restore(restore),
      .clr_err(clr_err), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we), .busy(busy),
      .depth(depth), .overflow(overflow), .underflow(underflow),
      .collide(collide)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: DUT write port has priority over the bench's host port.
   logic [15:0] rf [16];
   logic        hwe;
   logic [3:0]  ha;
   logic [15:0] hd;
   assign rf_rdata = rf[rf_raddr];
   always @(posedge clk) begin
      if (rf_we)    rf[rf_waddr] <= rf_wdata;
      else if (hwe) rf[ha]       <= hd;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: stack as a flat queue of saved words, frame in flight
   // collected separately so depth only moves when a frame completes.
   logic [15:0] m_stk[$];
   logic [15:0] m_buf[$];
   int          m_op  = 0;   // 0 idle, 1 saving, 2 loading
   int          m_cyc = 0;
   logic        m_ovf = 0, m_unf = 0, m_col = 0;

   always @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         m_stk.delete(); m_buf.delete();
         m_op = 0; m_cyc = 0;
         m_ovf = 0; m_unf = 0; m_col = 0;
      end else begin
         logic s_ovf, s_unf, s_col;
         int   md;
         s_ovf = 0; s_unf = 0; s_col = 0;
         md = m_stk.size() / NREGS;
         if (m_op == 0) begin
            if (backup && restore) s_col = 1;
            else if (backup) begin
               if (md == DEPTH) s_ovf = 1;
               else begin m_op = 1; m_cyc = 0; end
            end else if (restore) begin
               if (md == 0) s_unf = 1;
               else begin m_op = 2; m_cyc = 0; end
            end
         end else begin
            if (backup || restore) s_col = 1;
            if (m_op == 1) m_buf.push_back(rf[FIRST_REG + m_cyc]);
            if (m_cyc == NREGS - 1) begin
               if (m_op == 1) begin
                  foreach (m_buf[k]) m_stk.push_back(m_buf[k]);
                  m_buf.delete();
               end else begin
                  repeat (NREGS) void'(m_stk.pop_back());
               end
               m_op = 0; m_cyc = 0;
            end else begin
               m_cyc++;
            end
         end
         m_ovf = s_ovf | (m_ovf & ~clr_err);
         m_unf = s_unf | (m_unf & ~clr_err);
         m_col = s_col | (m_col & ~clr_err);
      end
   end

   logic cmp_en = 0;
   always @(negedge clk) begin
      if (cmp_en) begin
         int e_ra, e_wa, e_wd;
         e_ra = (m_op == 1) ? FIRST_REG + m_cyc : 0;
         e_wa = (m_op == 2) ? FIRST_REG + m_cyc : 0;
         e_wd = (m_op == 2) ? 32'(m_stk[m_stk.size() - NREGS + m_cyc]) : 0;
         chk("cmp_busy",     32'(busy),      32'(m_op != 0));
         chk("cmp_rf_we",    32'(rf_we),     32'(m_op == 2));
         chk("cmp_rf_raddr", 32'(rf_raddr),  e_ra);
         chk("cmp_rf_waddr", 32'(rf_waddr),  e_wa);
         chk("cmp_rf_wdata", 32'(rf_wdata),  e_wd);
         chk("cmp_depth",    32'(depth),     m_stk.size() / NREGS);
         chk("cmp_overflow", 32'(overflow),  32'(m_ovf));
         chk("cmp_underflow",32'(underflow), 32'(m_unf));
         chk("cmp_collide",  32'(collide),   32'(m_col));
      end
   end

   logic [3:0]  cap_ra [8];
   logic [3:0]  cap_wa [8];
   logic [15:0] cap_wd [8];
   logic        cap_we [8];
   logic [3:0]  cap_dp [8];
   int          cap_n;

   task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk); hwe = 1; ha = a; hd = d;
      @(negedge clk); hwe = 0;
   endtask

   task automatic pulse_clr();
      @(negedge clk); clr_err = 1;
      @(negedge clk); clr_err = 0;
   endtask

   // Issue one strobe pair, then record outputs on every busy cycle.
   task automatic xfer(input logic b, input logic r);
      @(negedge clk); backup = b; restore = r;
      @(negedge clk); backup = 0; restore = 0;
      cap_n = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy) begin
            cap_ra[cap_n] = rf_raddr; cap_wa[cap_n] = rf_waddr;
            cap_wd[cap_n] = rf_wdata; cap_we[cap_n] = rf_we;
            cap_dp[cap_n] = depth;
            cap_n++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int cnt;
      Reset = 0; backup = 0; restore = 0; clr_err = 0; hwe = 0; ha = 0; hd = 0;
      repeat (3) @(negedge clk);
      Reset = 1; cmp_en = 1;
      @(negedge clk);
      chk("rst_depth", 32'(depth), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_flags", 32'({overflow, underflow, collide}), 0);

      // Basic save
      for (int i = 0; i < 4; i++) wr_reg(4'(4 + i), 16'(16'h1111 * (i + 1)));
      xfer(1, 0);
      chk("save_busy_cycles", cap_n, 4);
      for (int i = 0; i < 4; i++) begin
         chk("save_raddr", 32'(cap_ra[i]), 4 + i);
         chk("save_we",    32'(cap_we[i]), 0);
      end
      chk("save_depth_last_cycle", 32'(cap_dp[3]), 0);
      chk("save_depth_end", 32'(depth), 1);

      // Save then restore
      for (int i = 0; i < 4; i++) wr_reg(4'(4 + i), 16'h0000);
      xfer(0, 1);
      chk("load_busy_cycles", cap_n, 4);
      for (int i = 0; i < 4; i++) begin
         chk("load_we",    32'(cap_we[i]), 1);
         chk("load_waddr", 32'(cap_wa[i]), 4 + i);
         chk("load_wdata", 32'(cap_wd[i]), 32'h1111 * (i + 1));
         chk("load_rf",    32'(rf[4 + i]), 32'h1111 * (i + 1));
      end
      chk("load_depth_end", 32'(depth), 0);

      // Nested frames
      for (int i = 0; i < 4; i++) wr_reg(4'(4 + i), 16'(16'hA000 + i));
      xfer(1, 0);
      for (int i = 0; i < 4; i++) wr_reg(4'(4 + i), 16'(16'hB000 + i));
      xfer(1, 0);
      chk("nest_depth2", 32'(depth), 2);
      for (int i = 0; i < 4; i++) wr_reg(4'(4 + i), 16'h0000);
      xfer(0, 1);
      chk("nest_depth1", 32'(depth), 1);
      for (int i = 0; i < 4; i++) chk("nest_first_b", 32'(rf[4 + i]), 32'hB000 + i);
      for (int i = 0; i < 4; i++) wr_reg(4'(4 + i), 16'h0000);
      xfer(0, 1);
      chk("nest_depth0", 32'(depth), 0);
      for (int i = 0; i < 4; i++) chk("nest_second_a", 32'(rf[4 + i]), 32'hA000 + i);

      // Overflow and underflow
      repeat (8) xfer(1, 0);
      chk("full_depth", 32'(depth), 8);
      xfer(1, 0);
      chk("ovf_no_busy", cap_n, 0);
      chk("ovf_flag",    32'(overflow), 1);
      chk("ovf_depth",   32'(depth), 8);
      pulse_clr();
      chk("ovf_cleared", 32'(overflow), 0);
      repeat (8) xfer(0, 1);
      xfer(0, 1);
      chk("unf_no_xfer", cap_n, 0);
      chk("unf_flag",    32'(underflow), 1);
      chk("unf_depth",   32'(depth), 0);
      pulse_clr();
      chk("unf_cleared", 32'(underflow), 0);

      // Collisions
      xfer(1, 1);
      chk("col_both_no_xfer", cap_n, 0);
      chk("col_both_flag",    32'(collide), 1);
      pulse_clr();
      chk("col_cleared", 32'(collide), 0);
      @(negedge clk); backup = 1;
      @(negedge clk); backup = 0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy) cnt++;
         restore = (i == 1);
         @(negedge clk);
      end
      restore = 0;
      chk("col_busy_cycles", cnt, 4);
      chk("col_busy_depth",  32'(depth), 1);
      chk("col_busy_flag",   32'(collide), 1);
      pulse_clr();

      // Reset abort during the second LOAD cycle, with collide set just before
      @(negedge clk); restore = 1;
      @(negedge clk); restore = 0; backup = 1;
      @(negedge clk); backup = 0;
      #2 Reset = 0;
      #1;
      chk("abort_busy",  32'(busy), 0);
      chk("abort_we",    32'(rf_we), 0);
      chk("abort_depth", 32'(depth), 0);
      chk("abort_flags", 32'({overflow, underflow, collide}), 0);
      @(negedge clk); Reset = 1;
      xfer(1, 0);
      chk("abort_after_cycles", cap_n, 4);
      chk("abort_after_depth",  32'(depth), 1);

      // Randomized traffic, alternating push-heavy and pop-heavy phases
      for (int c = 0; c < 1200; c++) begin
         int ph;
         @(negedge clk);
         ph      = (c / 150) % 2;
         backup  = ($urandom_range(0, 99) < ((ph == 0) ? 35 : 10));
         restore = ($urandom_range(0, 99) < ((ph == 0) ? 10 : 35));
         clr_err = ($urandom_range(0, 24) == 0);
         hwe     = 1'($urandom_range(0, 1));
         ha      = 4'($urandom_range(0, 15));
         hd      = 16'($urandom);
      end
      @(negedge clk);
      backup = 0; restore = 0; clr_err = 0; hwe = 0;
      repeat (6) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
